// File: rtl/io_port_driver.sv
// Bridges a CPU's memory-mapped I/O port pair to host-side valid/ready queues.
// Each change of OUTPORTout is one CPU write: it queues the word and advances INPORTin.
//   state  | meaning
//   IDLE   | waiting for run; OUTPORTout is tracked but never raises an event
//   RUN    | detecting writes as changes of OUTPORTout
//   STALL  | output queue was full on a write; holding the word in pending, stop=1
//   HALTED | CPU stopped; only host-side queue traffic remains until reset
module io_port_driver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] OUTPORTout,
  output logic [31:0] INPORTin,
  output logic        stop,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic        underflow,
  output logic [15:0] event_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL, HALTED} state_t;

  state_t state, state_nxt;

  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [PW-1:0] in_wr, in_rd, out_wr, out_rd;
  logic [PW:0]   in_cnt, out_cnt;
  logic [31:0]   cur_in, prev_out, pending;

  logic        in_full, in_empty, out_full, out_empty;
  logic        in_push, out_pop;
  logic        write_ev;
  logic        cpu_push, cpu_pop, set_underflow, set_halted, load_pending;
  logic [31:0] cpu_word;

  assign in_full   = (in_cnt == CNT_FULL);
  assign in_empty  = (in_cnt == '0);
  assign out_full  = (out_cnt == CNT_FULL);
  assign out_empty = (out_cnt == '0);

  assign in_ready  = !in_full;
  assign out_valid = !out_empty;
  assign out_data  = out_mem[out_rd];
  assign INPORTin  = cur_in;

  assign in_push  = in_valid && in_ready;
  assign out_pop  = out_valid && out_ready;
  assign write_ev = (state == RUN) && (OUTPORTout != prev_out);

  // Fullness is judged on the pre-edge count, so a host pop on a full queue
  // never lets a CPU word slip in on the same edge.
  always_comb begin
    state_nxt     = state;
    cpu_push      = 1'b0;
    cpu_word      = OUTPORTout;
    load_pending  = 1'b0;
    set_halted    = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = RUN;
      end
      RUN: begin
        if (write_ev && out_full) begin
          load_pending = 1'b1;
          state_nxt    = STALL;
        end else begin
          cpu_push = write_ev;
          if (!run) begin
            state_nxt  = HALTED;
            set_halted = 1'b1;
          end
        end
      end
      STALL: begin
        if (!out_full) begin
          cpu_push   = 1'b1;
          cpu_word   = pending;
          state_nxt  = run ? RUN : HALTED;
          set_halted = !run;
        end
      end
      default: ;
    endcase
    cpu_pop       = cpu_push && !in_empty;
    set_underflow = cpu_push && in_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      stop        <= 1'b0;
      prev_out    <= '0;
      pending     <= '0;
      cur_in      <= '0;
      event_count <= '0;
      halted      <= 1'b0;
      underflow   <= 1'b0;
      in_wr       <= '0;
      in_rd       <= '0;
      in_cnt      <= '0;
      out_wr      <= '0;
      out_rd      <= '0;
      out_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      stop     <= (state_nxt == STALL);
      prev_out <= OUTPORTout;
      if (load_pending) pending <= OUTPORTout;
      if (cpu_push) event_count <= event_count + 16'd1;
      if (cpu_pop) cur_in <= in_mem[in_rd];
      if (set_halted) halted <= 1'b1;
      if (set_underflow) underflow <= 1'b1;

      if (in_push) in_wr <= in_wr + 1'b1;
      if (cpu_pop) in_rd <= in_rd + 1'b1;
      in_cnt <= in_cnt + {{PW{1'b0}}, in_push} - {{PW{1'b0}}, cpu_pop};

      if (cpu_push) out_wr <= out_wr + 1'b1;
      if (out_pop) out_rd <= out_rd + 1'b1;
      out_cnt <= out_cnt + {{PW{1'b0}}, cpu_push} - {{PW{1'b0}}, out_pop};
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers and counts.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= in_data;
    if (cpu_push) out_mem[out_wr] <= cpu_word;
  end

endmodule

// File: tb/tb_io_port_driver.sv
// Directed scenarios plus randomized traffic for io_port_driver, checked against
// a queue-based reference model of the CPU port behaviour.
module tb_io_port_driver;

  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] OUTPORTout;
  logic [31:0] INPORTin;
  logic        stop;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic        underflow;
  logic [15:0] event_count;

  io_port_driver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .OUTPORTout(OUTPORTout),
    .INPORTin(INPORTin), .stop(stop), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .halted(halted), .underflow(underflow),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          m_mode;
  logic [31:0] m_prev, m_pend, m_cur;
  bit          m_halted, m_under;
  logic [15:0] m_cnt;
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_prev = '0;
    m_pend = '0;
    m_cur = '0;
    m_halted = 0;
    m_under = 0;
    m_cnt = '0;
    in_q.delete();
    out_q.delete();
  endtask

  // One rising edge of the CPU-port rules, applied to the pre-edge queue contents.
  task automatic model_step();
    bit in_had, in_was_full, out_had, out_was_full, deliver;
    logic [31:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    in_had       = in_q.size() > 0;
    in_was_full  = in_q.size() == DEPTH;
    out_had      = out_q.size() > 0;
    out_was_full = out_q.size() == DEPTH;
    deliver = 0;
    w = '0;
    case (m_mode)
      M_IDLE: if (run) m_mode = M_RUN;
      M_RUN: begin
        if (OUTPORTout != m_prev) begin
          if (out_was_full) begin
            m_pend = OUTPORTout;
            m_mode = M_STALL;
          end else begin
            deliver = 1;
            w = OUTPORTout;
          end
        end
        if (m_mode == M_RUN && !run) begin
          m_mode = M_HALT;
          m_halted = 1;
        end
      end
      M_STALL: begin
        if (!out_was_full) begin
          deliver = 1;
          w = m_pend;
          if (run) m_mode = M_RUN;
          else begin
            m_mode = M_HALT;
            m_halted = 1;
          end
        end
      end
      default: ;
    endcase
    m_prev = OUTPORTout;
    if (out_had && out_ready) void'(out_q.pop_front());
    if (deliver) begin
      out_q.push_back(w);
      m_cnt = m_cnt + 16'd1;
      if (in_had) m_cur = in_q.pop_front();
      else m_under = 1;
    end
    if (in_valid && !in_was_full) in_q.push_back(in_data);
  endtask

  task automatic compare_all();
    chk("inport", INPORTin, m_cur);
    chk("stop", 32'(stop), 32'(m_mode == M_STALL));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("underflow", 32'(underflow), 32'(m_under));
    chk("event_count", 32'(event_count), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'(in_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(out_q.size() > 0));
    if (out_q.size() > 0) chk("out_data", out_data, out_q[0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data = w;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic write_out(input logic [31:0] w);
    OUTPORTout = w;
    cycle();
  endtask

  initial begin
    bit run_dropped;
    int pr;
    reset = 1'b0;
    run = 1'b0;
    OUTPORTout = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_inport", INPORTin, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stop", 32'(stop), 32'h0);
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // basic flow and starvation
    push_word(32'h11);
    push_word(32'h22);
    run = 1'b1;
    cycle();
    write_out(32'hA5);
    chk("basic_inport1", INPORTin, 32'h11);
    chk("basic_out_data", out_data, 32'hA5);
    chk("basic_count1", 32'(event_count), 32'd1);
    write_out(32'hB6);
    chk("basic_inport2", INPORTin, 32'h22);
    chk("basic_count2", 32'(event_count), 32'd2);
    write_out(32'hC7);
    chk("starve_inport", INPORTin, 32'h22);
    chk("starve_underflow", 32'(underflow), 32'h1);
    chk("starve_count", 32'(event_count), 32'd3);

    // backpressure
    do_reset();
    OUTPORTout = '0;
    run = 1'b1;
    cycle();
    for (int i = 1; i <= 5; i++) begin
      write_out(32'(i));
      if (i == 4) chk("bp_stop_before", 32'(stop), 32'h0);
    end
    chk("bp_stop", 32'(stop), 32'h1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_stop_held", 32'(stop), 32'h1);
    chk("bp_head_after_pop", out_data, 32'd2);
    cycle();
    chk("bp_stop_clear", 32'(stop), 32'h0);
    chk("bp_count", 32'(event_count), 32'd5);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("bp_order", out_data, 32'(i));
      cycle();
    end
    chk("bp_drained", 32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // halt during stall
    for (int i = 6; i <= 10; i++) write_out(32'(i));
    chk("halt_stall", 32'(stop), 32'h1);
    run = 1'b0;
    cycle();
    chk("halt_not_yet", 32'(halted), 32'h0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("halt_not_yet2", 32'(halted), 32'h0);
    cycle();
    chk("halt_set", 32'(halted), 32'h1);
    chk("halt_stop", 32'(stop), 32'h0);
    chk("halt_count", 32'(event_count), 32'd10);
    write_out(32'h77);
    write_out(32'h78);
    chk("halt_ignored", 32'(event_count), 32'd10);
    out_ready = 1'b1;
    push_word(32'hABCD);
    cycle();
    out_ready = 1'b0;

    // asynchronous reset in the middle of a stall
    do_reset();
    OUTPORTout = '0;
    run = 1'b1;
    cycle();
    push_word(32'h33);
    for (int i = 1; i <= 5; i++) write_out(32'(i + 100));
    chk("rs_stall", 32'(stop), 32'h1);
    chk("rs_inport", INPORTin, 32'h33);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rs_out_valid", 32'(out_valid), 32'h0);
    chk("rs_stop", 32'(stop), 32'h0);
    chk("rs_count", 32'(event_count), 32'h0);
    chk("rs_inport0", INPORTin, 32'h0);
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    // IDLE filtering
    run = 1'b0;
    OUTPORTout = 32'h5;
    cycle();
    cycle();
    run = 1'b1;
    repeat (3) cycle();
    chk("idle_count", 32'(event_count), 32'h0);
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // randomized traffic
    for (int ep = 0; ep < 3; ep++) begin
      pr = (ep == 0) ? 50 : (ep == 1) ? 20 : 85;
      do_reset();
      run = 1'b0;
      run_dropped = 0;
      for (int c = 0; c < 400; c++) begin
        in_valid  = ($urandom_range(0, 99) < 50);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 99) < pr);
        if ($urandom_range(0, 9) < 4) OUTPORTout = 32'($urandom_range(0, 7));
        if (c == 5) run = 1'b1;
        if (c > 60 && !run_dropped && $urandom_range(0, 199) == 0) begin
          run = 1'b0;
          run_dropped = 1;
        end
        cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_port_driver.md
IO_PORT_DRIVER -- requirements
Module: io_port_driver

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  CPU run indicator.
- OUTPORTout  in  32  CPU output-port value.
- INPORTin  out  32  word presented to the CPU input port.
- stop  out  1  CPU stall request.
- in_data  in  32  host word to queue for the CPU.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  input queue can accept a word.
- out_data  out  32  oldest CPU-written word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts out_data.
- halted  out  1  sticky CPU-halt flag.
- underflow  out  1  sticky input-starvation flag.
- event_count  out  16  number of CPU output writes accepted.
REQ-002 The block SHALL have the parameter DEPTH, default 4, giving the entry count of each queue (power of two, at least 2).

Function
REQ-003 The input queue SHALL be a FIFO of DEPTH x 32, with in_ready = !in_full; a push occurs when in_valid && in_ready.
REQ-004 The output queue SHALL be a FIFO of DEPTH x 32, with out_valid = !out_empty and out_data = head; a pop occurs when out_valid && out_ready.
REQ-005 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked 0..DEPTH, with no overflow or underflow of either queue.
REQ-006 INPORTin SHALL be driven from a register cur_in, not combinationally from the queue head.
REQ-007 The block SHALL have four states, IDLE, RUN, STALL and HALTED, encoded in one state register.
REQ-008 In IDLE, prev_out SHALL load OUTPORTout every cycle; when run=1 the state goes to RUN, and no event is raised in IDLE.
REQ-009 A write event SHALL occur in RUN when OUTPORTout != prev_out; prev_out SHALL load OUTPORTout every cycle in RUN.
REQ-010 On a write event with the output queue not full, OUTPORTout SHALL be pushed into the output queue on the same edge, and event_count SHALL increment (wrapping 0xFFFF -> 0).
REQ-011 On a write event with the input queue non-empty, its head SHALL be popped into cur_in on the same edge.
- If the input queue is empty, cur_in SHALL hold its value and underflow SHALL set.
REQ-012 On a write event with the output queue full, OUTPORTout SHALL be captured into a pending register and the state SHALL go to STALL.
REQ-013 In STALL, stop SHALL be 1 and no new write events are detected; prev_out continues to track OUTPORTout.
REQ-014 On the first edge in STALL where the output queue is not full, the pending word SHALL be pushed, the REQ-010/REQ-011 side effects SHALL apply, and the state returns to RUN.
REQ-015 stop SHALL be a registered output: it equals 1 in exactly the cycles where state == STALL.
REQ-016 Simultaneous push and pop on a full output queue SHALL NOT count as "not full" for the REQ-012 check (conservative); push and pop on the same edge SHALL otherwise be legal on both queues.
REQ-017 In RUN, run=0 SHALL move the state to HALTED and set halted on the same edge.
- Any write event in that same cycle SHALL still be processed.
REQ-018 From STALL, run=0 SHALL keep the state in STALL until the pending word is pushed, then go to HALTED.
REQ-019 HALTED SHALL be terminal until reset: no events are detected, while host push and pop on both queues continue to operate.
REQ-020 halted and underflow SHALL be sticky and cleared only by reset.

Reset
REQ-021 Reset low SHALL asynchronously set:
- state = IDLE;
- both queues empty;
- cur_in, prev_out, pending and event_count = 0;
- stop, halted and underflow = 0;
- in_ready = 1 and out_valid = 0.
REQ-022 Reset asserted mid-operation, including in STALL, SHALL discard all queued and pending data, with no partial push.
REQ-023 Release of reset SHALL take effect on the first rising clk edge after reset goes high.

Verification
REQ-024 Basic flow: push 0x11, 0x22; run=1; OUTPORTout 0 -> 0xA5 -> INPORTin=0x11, out_data=0xA5, event_count=1; then -> 0xB6 -> INPORTin=0x22, event_count=2.
REQ-025 Starvation: input queue empty; OUTPORTout changes -> INPORTin unchanged, underflow=1, word still queued.
REQ-026 Backpressure: out_ready=0; DEPTH+1 distinct writes -> stop=1 after the 5th write (DEPTH=4); one pop -> the 5th word appears in order, stop=0 the next cycle, event_count=5.
REQ-027 Halt: run 1 -> 0 during STALL -> halted=0 until the pending word is pushed, then halted=1 and state HALTED; further OUTPORTout changes are ignored.
REQ-028 Reset mid-STALL with a full output queue -> out_valid=0, stop=0, event_count=0, INPORTin=0 immediately (asynchronous).
REQ-029 IDLE filtering: OUTPORTout=0x5 while run=0, then run=1 with OUTPORTout held -> no event, event_count=0.
